instr_sequencer: RTL and testbench

- Consumer stage directly downstream of the AXIS fetch unit.
- On the fetch unit's program-loaded pulse (VALID_FU2PE), walks the instruction BRAM from address 0 and decodes each word.
- For each instruction, reads operand words from the matrix A and matrix B BRAMs and streams {op, a, b} beats to the PE array over a valid/ready handshake.
- Ends on HALT or instruction-address wrap; pulses done.

---
 rtl/instr_seq_pkg.sv | 42 ++++
 rtl/seq_skid_fifo.sv | 45 ++++
 rtl/instr_sequencer.sv | 133 +++++++++++++
 tb/tb_instr_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: opcodes, instruction field layout, FSM states and FIFO beat format
package instr_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_MAC  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_LSB   = 28;
    localparam int OP_W     = 4;
    localparam int BASE_LSB = 18;
    localparam int CNT_LSB  = 8;
    localparam int FIELD_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_STREAM,
        S_DRAIN
    } state_t;

    // spare bit pads the beat to the 70-bit FIFO word
    typedef struct packed {
        logic        spare;
        logic [3:0]  op;
        logic        last;
        logic [31:0] a;
        logic [31:0] b;
    } beat_t;

    function automatic logic op_streams(input logic [3:0] op);
        return op >= OP_ADD && op <= OP_MAC;
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return !op_streams(op) && op != OP_NOP && op != OP_HALT;
    endfunction

endpackage

// File: rtl/seq_skid_fifo.sv
// seq_skid_fifo: synchronous FIFO with count/full/empty; push and pop may coincide
module seq_skid_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: walks the instruction BRAM after a program load and streams
// {op, a, b} operand beats to the PE array through a small skid FIFO
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int BRAM_DEPTH       = 10,
    parameter int INSTR_BRAM_DEPTH = 11,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        VALID_FU2PE,
    output logic [INSTR_BRAM_DEPTH-1:0] instr_addr,
    output logic                        instr_rd_en,
    input  logic [31:0]                 instr_dout,
    output logic [BRAM_DEPTH-1:0]       mat_a_addr,
    output logic                        mat_a_rd_en,
    input  logic [31:0]                 mat_a_dout,
    output logic [BRAM_DEPTH-1:0]       mat_b_addr,
    output logic                        mat_b_rd_en,
    input  logic [31:0]                 mat_b_dout,
    output logic                        pe_valid,
    input  logic                        pe_ready,
    output logic [3:0]                  pe_op,
    output logic [31:0]                 pe_a,
    output logic [31:0]                 pe_b,
    output logic                        pe_last,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                      state;
    logic [INSTR_BRAM_DEPTH-1:0] ip;
    logic [3:0]                  op, inflight_op, dec_op;
    logic [FIELD_W-1:0]          base, cnt, idx;
    logic                        final_instr, inflight, inflight_last;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_full, fifo_empty, issue, drained;
    logic [BRAM_DEPTH-1:0]       rd_addr;
    beat_t                       push_beat, head;
    logic                        unused;

    assign dec_op  = instr_dout[OP_LSB +: OP_W];
    // reserve a FIFO slot for every read whose data has not yet landed
    assign issue   = state == S_STREAM && int'(fifo_count) + int'(inflight) < FIFO_DEPTH;
    assign drained = fifo_empty && !inflight;
    assign rd_addr = BRAM_DEPTH'(base) + BRAM_DEPTH'(idx);

    assign instr_addr  = ip;
    assign instr_rd_en = state == S_FETCH;
    assign mat_a_addr  = rd_addr;
    assign mat_b_addr  = rd_addr;
    assign mat_a_rd_en = issue;
    assign mat_b_rd_en = issue;
    assign done        = state == S_DRAIN && drained;

    assign push_beat = '{spare: 1'b0, op: inflight_op, last: inflight_last, a: mat_a_dout, b: mat_b_dout};
    assign pe_valid  = !fifo_empty;
    assign pe_op     = head.op;
    assign pe_last   = head.last;
    assign pe_a      = head.a;
    assign pe_b      = head.b;
    assign unused    = ^{instr_dout[CNT_LSB-1:0], head.spare, fifo_full};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            ip            <= '0;
            op            <= OP_NOP;
            base          <= '0;
            cnt           <= '0;
            idx           <= '0;
            final_instr   <= 1'b0;
            inflight      <= 1'b0;
            inflight_op   <= OP_NOP;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_op   <= op;
            inflight_last <= idx == cnt;
            case (state)
                S_IDLE: if (VALID_FU2PE) begin
                    ip    <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b1;
                    state <= S_FETCH;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ip          <= ip + INSTR_BRAM_DEPTH'(1);
                    op          <= dec_op;
                    base        <= instr_dout[BASE_LSB +: FIELD_W];
                    cnt         <= instr_dout[CNT_LSB +: FIELD_W];
                    idx         <= '0;
                    final_instr <= &ip;
                    err         <= err | op_illegal(dec_op);
                    state       <= op_streams(dec_op) ? S_STREAM :
                                   (dec_op == OP_HALT || &ip) ? S_DRAIN : S_FETCH;
                end
                S_STREAM: if (issue) begin
                    idx <= idx + FIELD_W'(1);
                    if (idx == cnt)
                        state <= final_instr ? S_DRAIN : S_FETCH;
                end
                S_DRAIN: if (drained) begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    seq_skid_fifo #(
        .WIDTH($bits(beat_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (ACLK),
        .rst  (ARESET),
        .push (inflight),
        .pop  (pe_ready),
        .din  (push_beat),
        .dout (head),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and randomized programs checked against a program-level beat model
module tb_instr_sequencer;

    logic        ACLK = 0, ARESET = 1, VALID_FU2PE = 0, pe_ready = 0;
    logic [10:0] instr_addr;
    logic [9:0]  mat_a_addr, mat_b_addr;
    logic        instr_rd_en, mat_a_rd_en, mat_b_rd_en;
    logic [31:0] instr_dout, mat_a_dout, mat_b_dout, pe_a, pe_b;
    logic        pe_valid, pe_last, busy, done, err;
    logic [3:0]  pe_op;

    logic [31:0] instr_mem [2048];
    logic [31:0] a_mem [1024];
    logic [31:0] b_mem [1024];

    int checks = 0, fails = 0, cyc = 0;
    int done_n, done_cyc, last_beat, first_beat, first_issue;
    logic [68:0] got[$], exp_q[$], prev_beat;
    logic prev_stall = 0, exp_err;

    instr_sequencer dut (
        .ACLK(ACLK), .ARESET(ARESET), .VALID_FU2PE(VALID_FU2PE),
        .instr_addr(instr_addr), .instr_rd_en(instr_rd_en), .instr_dout(instr_dout),
        .mat_a_addr(mat_a_addr), .mat_a_rd_en(mat_a_rd_en), .mat_a_dout(mat_a_dout),
        .mat_b_addr(mat_b_addr), .mat_b_rd_en(mat_b_rd_en), .mat_b_dout(mat_b_dout),
        .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_op(pe_op), .pe_a(pe_a), .pe_b(pe_b),
        .pe_last(pe_last), .busy(busy), .done(done), .err(err)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (instr_rd_en) instr_dout <= instr_mem[instr_addr];
        if (mat_a_rd_en) mat_a_dout <= a_mem[mat_a_addr];
        if (mat_b_rd_en) mat_b_dout <= b_mem[mat_b_addr];
    end

    function automatic void check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    always @(negedge ACLK) begin
        cyc++;
        if (!ARESET) begin
            if (prev_stall) begin
                check("stall_valid", pe_valid, 1'b1);
                check("stall_stable", {pe_op, pe_last, pe_a, pe_b}, prev_beat);
            end
            if (mat_a_rd_en && first_issue < 0) first_issue = cyc;
            if (pe_valid && pe_ready) begin
                if (got.size() == 0) first_beat = cyc;
                got.push_back({pe_op, pe_last, pe_a, pe_b});
                last_beat = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
        prev_stall = pe_valid && !pe_ready && !ARESET;
        prev_beat  = {pe_op, pe_last, pe_a, pe_b};
    end

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [9:0] base, input logic [9:0] cnt);
        return {op, base, cnt, 8'($urandom)};
    endfunction

    // expected beat stream: walk the program until HALT or the end of instruction memory
    task automatic model();
        logic [31:0] w;
        logic [3:0]  o;
        int n, addr;
        exp_q.delete();
        exp_err = 0;
        for (int pc = 0; pc < 2048; pc++) begin
            w = instr_mem[pc];
            o = w[31:28];
            n = int'(w[17:8]) + 1;
            if (o == 4'hF) break;
            if (o >= 1 && o <= 4)
                for (int k = 0; k < n; k++) begin
                    addr = (int'(w[27:18]) + k) % 1024;
                    exp_q.push_back({o, k == n - 1, a_mem[addr], b_mem[addr]});
                end
            else if (o != 0)
                exp_err = 1;
        end
    endtask

    task automatic start();
        got.delete();
        done_n = 0;
        first_issue = -1;
        @(posedge ACLK); #1 VALID_FU2PE = 1;
        @(posedge ACLK); #1 VALID_FU2PE = 0;
    endtask

    // mode 0: ready high, 1: one on / two off, 2: random
    task automatic run_prog(input int mode, input int extra_start, input string tag);
        int t = 0;
        model();
        start();
        while (done_n == 0 && t < 20000) begin
            pe_ready    = mode == 0 ? 1'b1 : mode == 1 ? (t % 3 == 0) : 1'($urandom_range(0, 1));
            VALID_FU2PE = extra_start != 0 && t == extra_start;
            @(posedge ACLK); #1;
            t++;
        end
        VALID_FU2PE = 0;
        pe_ready = 1;
        repeat (4) @(posedge ACLK);
        #1;
        check({tag, "_timeout"}, t < 20000, 1'b1);
        check({tag, "_nbeats"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("%s_beat%0d", tag, k), k < got.size() ? got[k] : 69'h0, exp_q[k]);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_done_once"}, done_n, 1);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) instr_mem[i] = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            a_mem[i] = i;
            b_mem[i] = 32'h100 + i;
        end
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_outputs", {instr_rd_en, mat_a_rd_en, mat_b_rd_en, pe_valid, pe_last, busy, done, err}, 8'h0);
        @(posedge ACLK); #1 ARESET = 0;

        // ADD base=0, 4 beats, then HALT
        clear_prog();
        instr_mem[0] = ins(4'h1, 10'd0, 10'd3);
        instr_mem[1] = ins(4'hF, 10'd0, 10'd0);
        run_prog(0, 0, "add4");
        check("add4_count", got.size(), 4);
        check("add4_b_last", got.size() > 3 ? got[3][31:0] : 32'h0, 32'h103);
        check("add4_first_latency", first_beat - first_issue, 2);
        check("add4_done_after_last", done_cyc - last_beat, 1);

        run_prog(1, 0, "add4_stall");

        // NOP, illegal, MUL wrapping the matrix address space, HALT
        for (int i = 0; i < 1024; i++) begin
            a_mem[i] = $urandom;
            b_mem[i] = $urandom;
        end
        clear_prog();
        instr_mem[0] = ins(4'h0, 10'h155, 10'd9);
        instr_mem[1] = ins(4'h7, 10'd0, 10'd0);
        instr_mem[2] = ins(4'h3, 10'h3FE, 10'd2);
        instr_mem[3] = ins(4'hF, 10'd0, 10'd0);
        run_prog(2, 0, "illegal_wrap");
        check("illegal_err_flag", err, 1'b1);

        // 2048 single-beat MACs with no HALT: ends on instruction address wrap
        for (int i = 0; i < 2048; i++) instr_mem[i] = ins(4'h4, 10'($urandom), 10'd0);
        run_prog(0, 0, "mac_wrap");
        check("mac_wrap_count", got.size(), 2048);

        // reset in the middle of an 8-beat ADD
        clear_prog();
        instr_mem[0] = ins(4'h1, 10'($urandom), 10'd7);
        instr_mem[1] = ins(4'hF, 10'd0, 10'd0);
        pe_ready = 1;
        start();
        for (int t = 0; t < 50 && got.size() < 2; t++) @(posedge ACLK);
        #1;
        check("midrst_streaming", got.size() >= 2, 1'b1);
        ARESET = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        check("midrst_outputs", {pe_valid, busy, done, mat_a_rd_en, instr_rd_en}, 5'h0);
        @(posedge ACLK); #1 ARESET = 0;
        check("midrst_no_done", done_n, 0);
        run_prog(2, 0, "rerun");

        // restart pulse while busy is ignored
        run_prog(0, 5, "restart_ignored");

        // random programs
        for (int r = 0; r < 3; r++) begin
            clear_prog();
            for (int i = 0; i < 12; i++)
                instr_mem[i] = ins(4'($urandom_range(0, 15)), 10'($urandom), 10'($urandom_range(0, 5)));
            instr_mem[12] = ins(4'hF, 10'd0, 10'd0);
            run_prog(2, 0, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
